axi4_lite_slave_mem: RTL and testbench
======================================

Name: axi4_lite_slave_mem

Overview:
- AXI4-Lite responder backed by a word-addressed register-file memory.
- It is the target end of the DMA controller's AXI4-Lite master: it answers AR/R reads and AW/W/B writes.
- It serves as the source and destination memory for DMA block transfers in system simulation and on-chip buffer use.
- The read and write channels run independently and concurrently, each with its own FSM.

Parameters:
- DATA_W, 32, data width in bits; fixed at 32 for AXI4-Lite.
- ADDR_W, 32, address width in bits.
- DEPTH, 64, number of 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_CYCLES, 2, extra response latency in cycles; used only when SLV_WAIT_STATES_EN is defined. Range 0-15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- AWADDR  in  ADDR_W  write address
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATA_W  write data
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- ARADDR  in  ADDR_W  read address
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATA_W  read data
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- RRESP  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - All outputs go to 0: AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA.
  - Both FSMs go to IDLE.
  - Memory contents are not cleared.
- Address decode:
  - offset = addr - BASE_ADDR.
  - In range when offset < DEPTH*4. Word index = offset[log2(DEPTH)+1:2]. Bits [1:0] are ignored.
  - Out of range produces SLVERR. Out-of-range writes are discarded; out-of-range reads return RDATA = 0.
- Write FSM, states W_IDLE, W_RESP (W_WAIT only with the macro):
  - W_IDLE:
    - AWREADY = 1 until AW is captured. WREADY = 1 until W is captured.
    - An AWVALID&AWREADY handshake latches AWADDR and drops AWREADY on the next cycle. W is handled the same way, independently.
    - AW and W may arrive in either order or in the same cycle.
  - Commit edge: the clock edge at which both AW and W are held or being accepted.
    - The memory write occurs (if in range).
    - BVALID goes to 1 and BRESP is set; both readies go to 0. Next state is W_RESP.
    - Minimum latency from a simultaneous AW+W handshake to BVALID is 1 cycle.
  - W_RESP:
    - BVALID and BRESP are held stable until BREADY.
    - On BVALID&BREADY: BVALID goes to 0, AWREADY and WREADY go to 1, next state is W_IDLE.
    - The next AW/W can be accepted at the earliest 1 cycle after the B handshake.
- Read FSM, states R_IDLE, R_DATA (R_WAIT only with the macro):
  - R_IDLE: ARREADY = 1.
  - On ARVALID&ARREADY:
    - ARREADY goes to 0.
    - RDATA is loaded from the array at that same edge (data before any write committing at that edge).
    - RRESP is set, RVALID goes to 1, next state is R_DATA.
    - Latency from AR handshake to RVALID is 1 cycle.
  - R_DATA:
    - RDATA, RRESP and RVALID are held stable until RREADY.
    - On RVALID&RREADY: RVALID goes to 0, ARREADY goes to 1, next state is R_IDLE.
- Concurrency:
  - A read and a write may be in flight at once.
  - A read of the address being committed on the same edge returns the old data. A read handshake one or more cycles after the commit returns the new data.
- One outstanding transaction per channel; no ID or ordering logic.
- Reset mid-transaction: the transaction is abandoned, VALIDs drop immediately, and no partial write occurs after reset.
- A stalled master (BREADY or RREADY held at 0) holds the slave indefinitely. No timeout.

Optional Feature:
- Macro: SLV_WAIT_STATES_EN.
- Defined:
  - After the commit edge, the write FSM enters W_WAIT. After the AR handshake, the read FSM enters R_WAIT.
  - Each channel has its own 4-bit down-counter loaded with WAIT_CYCLES.
  - BVALID/RVALID assert when the counter reaches 0, i.e. latency is 1+WAIT_CYCLES.
  - The memory write still occurs at the commit edge; RDATA is still captured at the AR handshake.
  - WAIT_CYCLES = 0 behaves identically to the undefined case.
- Undefined: the wait states and counters are absent; latencies are as stated above.

Test Plan:
- Simultaneous AW+W at 0x08, data 0xDEADBEEF; BREADY held 1 -> BVALID for exactly 1 cycle, 1 cycle after the handshake, BRESP = 00. A later read at 0x08 returns 0xDEADBEEF with RRESP = 00 and RVALID 1 cycle after the AR handshake.
- W (0x12345678) sent 3 cycles before AW (0x0C) -> WREADY low after the W handshake; BVALID 1 cycle after the AW handshake; readback of 0x0C = 0x12345678.
- BREADY and RREADY held 0 for 5 cycles -> BVALID/RVALID and RDATA stay stable; AWREADY/ARREADY stay 0 until the respective handshake completes.
- Write 0xA5A5A5A5 to 0x100 with DEPTH = 64 (out of range) -> BRESP = 10. A read at 0x100 gives RDATA = 0, RRESP = 10. Word 0x00 is unchanged.
- Sequence a DMA-style transfer: four words written at 0x20..0x2C, then 0x20..0x2C read back with an overlapping read of 0x24 on the commit edge of a new write of 0x55 to 0x24 -> the overlapping read returns the old value; a subsequent read returns 0x55.
- With SLV_WAIT_STATES_EN and WAIT_CYCLES = 3 -> BVALID and RVALID each appear 4 cycles after their handshakes. Assert reset during W_WAIT -> BVALID = 0 and all readies 0 immediately, and the FSM is in W_IDLE after release.

Source files
------------

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite responder over a word-addressed register file; read and write channels run independently.
// Optional macro SLV_WAIT_STATES_EN adds WAIT_CYCLES of response latency per channel.
module axi4_lite_slave_mem #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [1:0]        RRESP,
  output logic [1:0]        o_dbg_wr_state,
  output logic [1:0]        o_dbg_rd_state
);
  // Handshake rule on every channel: a beat transfers on the rising edge where VALID and READY
  // are both high; once raised, VALID and its payload hold until that edge.
  localparam int                IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(DEPTH * 4);
  localparam logic [1:0]        OKAY      = 2'b00;
  localparam logic [1:0]        SLVERR    = 2'b10;

`ifdef SLV_WAIT_STATES_EN
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_RESP = 2'd1, W_WAIT = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd1, R_WAIT = 2'd2} rd_state_t;
  localparam logic [3:0] WAIT_LD     = 4'(WAIT_CYCLES);
  localparam logic       DIRECT_RESP = (WAIT_CYCLES == 0);
  logic [3:0] r_wcnt, r_rcnt;
`else
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_RESP = 2'd1} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd1} rd_state_t;
  logic w_unused_wait;
  assign w_unused_wait = (WAIT_CYCLES != 0);
`endif

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return (a - BASE_ADDR) < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  wr_state_t         r_wstate, w_wstate_nxt;
  rd_state_t         r_rstate, w_rstate_nxt;
  logic              r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]        r_bresp, r_rresp;
  logic [DATA_W-1:0] r_rdata, r_wdata;
  logic [ADDR_W-1:0] r_awaddr;
  logic              r_aw_held, r_w_held;

  logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_aw_hs  = AWVALID & r_awready;
  assign w_w_hs   = WVALID & r_wready;
  assign w_ar_hs  = ARVALID & r_arready;
  // Commit on the edge where both halves are either already held or arriving now.
  assign w_commit = (r_wstate == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
  assign w_waddr  = r_aw_held ? r_awaddr : AWADDR;
  assign w_wdata  = r_w_held ? r_wdata : WDATA;

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: if (w_commit) begin
`ifdef SLV_WAIT_STATES_EN
        w_wstate_nxt = DIRECT_RESP ? W_RESP : W_WAIT;
`else
        w_wstate_nxt = W_RESP;
`endif
      end
`ifdef SLV_WAIT_STATES_EN
      W_WAIT: if (r_wcnt == 4'd1) w_wstate_nxt = W_RESP;
`endif
      W_RESP: if (r_bvalid && BREADY) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
`ifdef SLV_WAIT_STATES_EN
      r_wcnt    <= 4'd0;
`endif
    end else begin
      r_wstate <= w_wstate_nxt;
      case (r_wstate)
        W_IDLE: begin
          if (w_commit) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bresp   <= f_in_range(w_waddr) ? OKAY : SLVERR;
`ifdef SLV_WAIT_STATES_EN
            r_bvalid  <= DIRECT_RESP;
            r_wcnt    <= WAIT_LD;
`else
            r_bvalid  <= 1'b1;
`endif
          end else begin
            if (w_aw_hs) begin
              r_aw_held <= 1'b1;
              r_awaddr  <= AWADDR;
              r_awready <= 1'b0;
            end else begin
              r_awready <= ~r_aw_held;
            end
            if (w_w_hs) begin
              r_w_held <= 1'b1;
              r_wdata  <= WDATA;
              r_wready <= 1'b0;
            end else begin
              r_wready <= ~r_w_held;
            end
          end
        end
`ifdef SLV_WAIT_STATES_EN
        W_WAIT: begin
          r_wcnt <= r_wcnt - 4'd1;
          if (r_wcnt == 4'd1) r_bvalid <= 1'b1;
        end
`endif
        W_RESP: if (r_bvalid && BREADY) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // No reset on the array: contents survive reset, and commit cannot fire while reset holds readies low.
  always_ff @(posedge clk) begin
    if (w_commit && f_in_range(w_waddr)) r_mem[f_index(w_waddr)] <= w_wdata;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: if (w_ar_hs) begin
`ifdef SLV_WAIT_STATES_EN
        w_rstate_nxt = DIRECT_RESP ? R_DATA : R_WAIT;
`else
        w_rstate_nxt = R_DATA;
`endif
      end
`ifdef SLV_WAIT_STATES_EN
      R_WAIT: if (r_rcnt == 4'd1) w_rstate_nxt = R_DATA;
`endif
      R_DATA: if (r_rvalid && RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= OKAY;
      r_rdata   <= '0;
`ifdef SLV_WAIT_STATES_EN
      r_rcnt    <= 4'd0;
`endif
    end else begin
      r_rstate <= w_rstate_nxt;
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rdata   <= f_in_range(ARADDR) ? r_mem[f_index(ARADDR)] : '0;
            r_rresp   <= f_in_range(ARADDR) ? OKAY : SLVERR;
`ifdef SLV_WAIT_STATES_EN
            r_rvalid  <= DIRECT_RESP;
            r_rcnt    <= WAIT_LD;
`else
            r_rvalid  <= 1'b1;
`endif
          end else begin
            r_arready <= 1'b1;
          end
        end
`ifdef SLV_WAIT_STATES_EN
        R_WAIT: begin
          r_rcnt <= r_rcnt - 4'd1;
          if (r_rcnt == 4'd1) r_rvalid <= 1'b1;
        end
`endif
        R_DATA: if (r_rvalid && RREADY) begin
          r_rvalid  <= 1'b0;
          r_arready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign AWREADY        = r_awready;
  assign WREADY         = r_wready;
  assign BVALID         = r_bvalid;
  assign BRESP          = r_bresp;
  assign ARREADY        = r_arready;
  assign RVALID         = r_rvalid;
  assign RRESP          = r_rresp;
  assign RDATA          = r_rdata;
  assign o_dbg_wr_state = r_wstate;
  assign o_dbg_rd_state = r_rstate;
endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Randomized bench for axi4_lite_slave_mem against an array model of the memory and the response rules.
module tb_axi4_lite_slave_mem;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef SLV_WAIT_STATES_EN
  localparam int WAITS = 3;
`else
  localparam int WAITS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP, dbg_wr, dbg_rd;
  logic [31:0] RDATA;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_mem [DEPTH];
  bit          known [DEPTH];
  logic [31:0] exp_q [$];

  axi4_lite_slave_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITS)) dut (
    .clk(clk), .reset(reset),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP),
    .o_dbg_wr_state(dbg_wr), .o_dbg_rd_state(dbg_rd)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a - BASE) < 32'(DEPTH * 4);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int skew, input int bdelay);
    bit aw_done = 0, w_done = 0, got = 0;
    int aw_hs = 0, w_hs = 0, last_hs, b_cyc = 0;
    int aw_start = (skew > 0) ? skew : 0;
    int w_start  = (skew < 0) ? -skew : 0;
    logic [1:0] exp_resp = in_rng(a) ? 2'b00 : 2'b10;
    BREADY = (bdelay == 0);
    for (int i = 0; i < 100 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      if (w_done && !aw_done) check_eq("wready_low_after_w", 32'(WREADY), 0);
      if (aw_done && !w_done) check_eq("awready_low_after_aw", 32'(AWREADY), 0);
      AWADDR = a; WDATA = d;
      AWVALID = !aw_done && (i >= aw_start);
      WVALID  = !w_done && (i >= w_start);
      if (AWVALID && AWREADY) begin aw_done = 1; aw_hs = cyc; end
      if (WVALID && WREADY) begin w_done = 1; w_hs = cyc; end
    end
    if (!(aw_done && w_done)) begin
      check_eq("aw_w_handshake_timeout", 0, 1);
      AWVALID = 0; WVALID = 0;
      return;
    end
    last_hs = (aw_hs > w_hs) ? aw_hs : w_hs;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      AWVALID = 0; WVALID = 0;
      if (BVALID) begin got = 1; b_cyc = cyc; break; end
    end
    check_eq("bvalid_seen", 32'(got), 1);
    if (!got) return;
    if (in_rng(a)) begin model_mem[idx_of(a)] = d; known[idx_of(a)] = 1; end
    check_eq("b_latency", 32'(b_cyc - last_hs), 32'(1 + WAITS));
    check_eq("bresp", 32'(BRESP), 32'(exp_resp));
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      check_eq("bvalid_hold", 32'(BVALID), 1);
      check_eq("bresp_hold", 32'(BRESP), 32'(exp_resp));
      check_eq("awready_stall", 32'(AWREADY), 0);
      check_eq("wready_stall", 32'(WREADY), 0);
    end
    BREADY = 1;
    @(negedge clk);
    check_eq("bvalid_drop", 32'(BVALID), 0);
    check_eq("awready_back", 32'(AWREADY), 1);
    check_eq("wready_back", 32'(WREADY), 1);
    BREADY = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input int rdelay);
    bit done = 0, got = 0;
    int ar_hs = 0, r_cyc = 0;
    logic [31:0] exp_d, held;
    logic [1:0]  exp_resp = in_rng(a) ? 2'b00 : 2'b10;
    RREADY = (rdelay == 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ARADDR = a; ARVALID = 1;
      if (ARREADY) begin
        done = 1; ar_hs = cyc;
        exp_q.push_back(in_rng(a) ? model_mem[idx_of(a)] : 32'h0);
        break;
      end
    end
    if (!done) begin check_eq("ar_handshake_timeout", 0, 1); ARVALID = 0; return; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ARVALID = 0;
      if (RVALID) begin got = 1; r_cyc = cyc; break; end
    end
    exp_d = exp_q.pop_front();
    check_eq("rvalid_seen", 32'(got), 1);
    if (!got) return;
    check_eq("r_latency", 32'(r_cyc - ar_hs), 32'(1 + WAITS));
    check_eq("rresp", 32'(RRESP), 32'(exp_resp));
    check_eq("rdata", RDATA, exp_d);
    held = exp_d;
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      check_eq("rvalid_hold", 32'(RVALID), 1);
      check_eq("rdata_hold", RDATA, held);
      check_eq("arready_stall", 32'(ARREADY), 0);
    end
    RREADY = 1;
    @(negedge clk);
    check_eq("rvalid_drop", 32'(RVALID), 0);
    check_eq("arready_back", 32'(ARREADY), 1);
    RREADY = 0;
  endtask

  initial begin
    logic [31:0] a, d;
    int k;
    repeat (3) @(negedge clk);
    check_eq("rst_awready", 32'(AWREADY), 0);
    check_eq("rst_wready", 32'(WREADY), 0);
    check_eq("rst_arready", 32'(ARREADY), 0);
    check_eq("rst_bvalid", 32'(BVALID), 0);
    check_eq("rst_rvalid", 32'(RVALID), 0);
    check_eq("rst_bresp", 32'(BRESP), 0);
    check_eq("rst_rresp", 32'(RRESP), 0);
    check_eq("rst_rdata", RDATA, 0);
    check_eq("rst_wr_idle", 32'(dbg_wr), 0);
    check_eq("rst_rd_idle", 32'(dbg_rd), 0);
    reset = 0;
    repeat (2) @(negedge clk);
    check_eq("idle_awready", 32'(AWREADY), 1);
    check_eq("idle_wready", 32'(WREADY), 1);
    check_eq("idle_arready", 32'(ARREADY), 1);

    do_write(32'h08, 32'hDEADBEEF, 0, 0);
    do_read(32'h08, 0);
    do_write(32'h0C, 32'h12345678, 3, 0);
    do_read(32'h0C, 0);
    do_write(32'h10, $urandom, -2, 5);
    do_read(32'h10, 5);

    do_write(32'h00, 32'h1111_2222, 0, 0);
    do_write(32'h100, 32'hA5A5A5A5, 0, 0);
    do_read(32'h100, 0);
    do_read(32'h00, 1);
    do_write(32'h0FC, 32'hCAFE_0001, 1, 0);
    do_read(32'h0FE, 0);

    for (int i = 0; i < 4; i++) do_write(32'h20 + 32'(4 * i), $urandom, 0, 0);
    for (int i = 0; i < 4; i++) do_read(32'h20 + 32'(4 * i), 0);
    fork
      do_write(32'h24, 32'h55, 0, 0);
      do_read(32'h24, 0);
    join
    do_read(32'h24, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = BASE + 32'(DEPTH * 4) + 4 * $urandom_range(0, 1000);
      else a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3);
      d = $urandom;
      do_write(a, d, int'($urandom_range(0, 6)) - 3, $urandom_range(0, 3));
      do_read(a, $urandom_range(0, 3));
      k = $urandom_range(0, DEPTH - 1);
      if (known[k] && $urandom_range(0, 1) == 1) do_read(BASE + 32'(4 * k), $urandom_range(0, 2));
    end

`ifdef SLV_WAIT_STATES_EN
    @(negedge clk);
    AWADDR = 32'h40; WDATA = 32'h0BAD_F00D; AWVALID = 1; WVALID = 1; BREADY = 1;
    @(negedge clk);
    AWVALID = 0; WVALID = 0;
    model_mem[16] = 32'h0BAD_F00D; known[16] = 1;
    reset = 1;
    #1;
    check_eq("midrst_bvalid", 32'(BVALID), 0);
    check_eq("midrst_awready", 32'(AWREADY), 0);
    check_eq("midrst_wready", 32'(WREADY), 0);
    check_eq("midrst_arready", 32'(ARREADY), 0);
    @(negedge clk);
    reset = 0; BREADY = 0;
    @(negedge clk);
    check_eq("midrst_wr_idle", 32'(dbg_wr), 0);
    repeat (WAITS + 2) begin
      @(negedge clk);
      check_eq("midrst_no_bvalid", 32'(BVALID), 0);
    end
    do_read(32'h40, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
